// File: rtl/sysarray_pkg.sv
// Shared encodings and defaults for the systolic-array sequencer.
// Imported by the controller and its valid-mask generator.
package sysarray_pkg;

    localparam int N_DEF  = 4;
    localparam int KW_DEF = 8;

    // Skew drain: 1 read latency + 2(N-1) skew + 1 PE register.
    function automatic int drain_len(input int n);
        return 2 * n;
    endfunction

    localparam int DRAIN = drain_len(N_DEF);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/sysarray_vld_mask.sv
// Valid window per skewed lane: lane i carries data while i+1 <= cnt < i+1+k.
// One instance serves rows, another columns; the formula is identical.
module sysarray_vld_mask
    import sysarray_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int KW = KW_DEF
) (
    input  logic [KW:0]   cnt,
    input  logic [KW-1:0] k_reg,
    input  logic          en,
    input  logic          hold,
    output logic [N-1:0]  vld
);

    logic [KW+1:0] cnt_x;
    logic [KW+1:0] k_x;

    assign cnt_x = {1'b0, cnt};
    assign k_x   = {2'b00, k_reg};

    for (genvar i = 0; i < N; i++) begin : g_lane
        localparam logic [KW+1:0] LO = (KW+2)'(i + 1);
        logic [KW+1:0] hi;
        assign hi     = k_x + LO;
        assign vld[i] = en && !hold && (cnt_x >= LO) && (cnt_x < hi);
    end

endmodule

// File: rtl/sysarray_ctrl.sv
// Sequencer for the NxN output-stationary systolic array: clear, stream K
// operand addresses, drain the skew, then pulse done.
module sysarray_ctrl
    import sysarray_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int KW = KW_DEF
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    input  logic          hold,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          acc_clr,
    output logic          array_en,
    output logic          rd_en,
    output logic [KW-1:0] rd_addr,
    output logic [N-1:0]  row_vld,
    output logic [N-1:0]  col_vld
);

    // Final advancing cycle is cnt == k + 2N - 1.
    localparam logic [KW:0] LAST_OFS = (KW+1)'(drain_len(N) - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [KW:0]   cnt;
    logic [KW-1:0] k_reg;
    logic          in_run;
    logic          adv;
    logic          last;

    assign in_run = (state == ST_RUN);
    assign adv    = in_run && !hold;
    assign last   = adv && (cnt == ({1'b0, k_reg} + LAST_OFS));

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                if (abort)              state_nxt = ST_IDLE;
                else if (k_reg == '0)   state_nxt = ST_DONE;
                else                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (abort)      state_nxt = ST_IDLE;
                else if (last)  state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            k_reg <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) k_reg <= k_len;
            if (!in_run)  cnt <= '0;
            else if (adv) cnt <= cnt + 1'b1;
        end
    end

    // Outputs decode registered state/cnt plus hold only.
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign acc_clr  = (state == ST_CLEAR);
    assign array_en = adv;
    assign rd_en    = adv && (cnt < {1'b0, k_reg});
    assign rd_addr  = rd_en ? cnt[KW-1:0] : '0;

    sysarray_vld_mask #(.N(N), .KW(KW)) u_row_mask (
        .cnt   (cnt),
        .k_reg (k_reg),
        .en    (in_run),
        .hold  (hold),
        .vld   (row_vld)
    );

    sysarray_vld_mask #(.N(N), .KW(KW)) u_col_mask (
        .cnt   (cnt),
        .k_reg (k_reg),
        .en    (in_run),
        .hold  (hold),
        .vld   (col_vld)
    );

endmodule

// File: tb/tb_sysarray_ctrl.sv
// Bench for sysarray_ctrl: directed scenarios plus random traffic against an
// operation-level model (clear cycle, advancing-step count, done cycle).
module tb_sysarray_ctrl;

    localparam int N  = 4;
    localparam int KW = 8;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          hold;
    logic          abort;
    logic          busy, done, acc_clr, array_en, rd_en;
    logic [KW-1:0] rd_addr;
    logic [N-1:0]  row_vld, col_vld;

    int checks   = 0;
    int failures = 0;

    int cyc;
    int done_cyc, clr_cyc, rd1_cyc, rd_count;

    // Model: operation active, in its clear cycle, advancing steps taken, K.
    bit m_act, m_clr;
    int m_adv, m_k;

    always #5 clock = ~clock;

    sysarray_ctrl #(.N(N), .KW(KW)) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .start    (start),
        .k_len    (k_len),
        .hold     (hold),
        .abort    (abort),
        .busy     (busy),
        .done     (done),
        .acc_clr  (acc_clr),
        .array_en (array_en),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .row_vld  (row_vld),
        .col_vld  (col_vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int op_len(input int k);
        return (k == 0) ? 0 : k + 2 * N;
    endfunction

    task automatic compare_outputs(input logic h);
        logic e_busy, e_done, e_clr, e_en, e_rd;
        logic [KW-1:0] e_addr;
        logic [N-1:0]  e_vld;
        e_busy = 0; e_done = 0; e_clr = 0; e_en = 0; e_rd = 0; e_addr = '0; e_vld = '0;
        if (m_act) begin
            e_busy = 1;
            if (m_clr) e_clr = 1;
            else if (m_adv < op_len(m_k)) begin
                if (!h) begin
                    e_en = 1;
                    e_rd = (m_adv < m_k);
                    e_addr = e_rd ? KW'(m_adv) : '0;
                    for (int i = 0; i < N; i++)
                        e_vld[i] = (m_adv >= i + 1) && (m_adv < i + 1 + m_k);
                end
            end else e_done = 1;
        end
        chk("busy", 32'(busy), 32'(e_busy));
        chk("done", 32'(done), 32'(e_done));
        chk("acc_clr", 32'(acc_clr), 32'(e_clr));
        chk("array_en", 32'(array_en), 32'(e_en));
        chk("rd_en", 32'(rd_en), 32'(e_rd));
        chk("rd_addr", 32'(rd_addr), 32'(e_addr));
        chk("row_vld", 32'(row_vld), 32'(e_vld));
        chk("col_vld", 32'(col_vld), 32'(e_vld));
    endtask

    task automatic model_advance(input logic st, input logic [KW-1:0] kl, input logic h, input logic ab);
        if (!m_act) begin
            if (st) begin m_act = 1; m_clr = 1; m_adv = 0; m_k = int'(kl); end
        end else if (m_clr) begin
            if (ab) m_act = 0; else m_clr = 0;
        end else if (m_adv < op_len(m_k)) begin
            if (ab) m_act = 0; else if (!h) m_adv++;
        end else m_act = 0;
    endtask

    task automatic step(input logic st, input logic [KW-1:0] kl, input logic h, input logic ab);
        @(negedge clock);
        start = st; k_len = kl; hold = h; abort = ab;
        #1;
        compare_outputs(h);
        if (done) done_cyc = cyc;
        if (acc_clr) clr_cyc = cyc;
        if (rd_en) rd_count++;
        if (rd_en && rd_addr == 8'd1) rd1_cyc = cyc;
        @(posedge clock);
        model_advance(st, kl, h, ab);
        cyc++;
    endtask

    task automatic begin_scn();
        cyc = 0; done_cyc = -1; clr_cyc = -1; rd1_cyc = -1; rd_count = 0;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 0; start = 0; k_len = '0; hold = 0; abort = 0;
        m_act = 0; m_clr = 0; m_adv = 0; m_k = 0;
        cyc = 0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        repeat (2) @(negedge clock);
        rst_n = 1;
        idle_steps(2);

        // k=3, no hold
        begin_scn();
        step(1'b1, 8'd3, 1'b0, 1'b0);
        for (int c = 1; c <= 15; c++) step(1'b0, 8'd3, 1'b0, 1'b0);
        chk("k3_clr_cycle", 32'(clr_cyc), 32'd1);
        chk("k3_done_cycle", 32'(done_cyc), 32'd13);
        chk("k3_reads", 32'(rd_count), 32'd3);

        // k=0 completes without reads
        begin_scn();
        step(1'b1, 8'd0, 1'b0, 1'b0);
        idle_steps(4);
        chk("k0_clr_cycle", 32'(clr_cyc), 32'd1);
        chk("k0_done_cycle", 32'(done_cyc), 32'd2);
        chk("k0_reads", 32'(rd_count), 32'd0);

        // hold during cycles 3-4
        begin_scn();
        step(1'b1, 8'd3, 1'b0, 1'b0);
        for (int c = 1; c <= 17; c++) step(1'b0, 8'd3, (c == 3 || c == 4), 1'b0);
        chk("hold_rd1_cycle", 32'(rd1_cyc), 32'd5);
        chk("hold_done_cycle", 32'(done_cyc), 32'd15);

        // abort at cycle 6 of k=5, restart at cycle 7
        begin_scn();
        step(1'b1, 8'd5, 1'b0, 1'b0);
        for (int c = 1; c <= 6; c++) step(1'b0, 8'd5, 1'b0, (c == 6));
        step(1'b1, 8'd5, 1'b0, 1'b0);
        chk("abort_no_done", 32'(done_cyc), 32'hffffffff);
        step(1'b0, 8'd5, 1'b0, 1'b0);
        chk("abort_restart_clr", 32'(clr_cyc), 32'd8);
        idle_steps(20);

        // start held high, k=2: back-to-back
        begin_scn();
        for (int c = 0; c <= 14; c++) step(1'b1, 8'd2, 1'b0, 1'b0);
        chk("b2b_done_cycle", 32'(done_cyc), 32'd12);
        chk("b2b_second_clr", 32'(clr_cyc), 32'd14);
        idle_steps(16);

        // async reset mid-run
        begin_scn();
        step(1'b1, 8'd6, 1'b0, 1'b0);
        for (int c = 1; c <= 5; c++) step(1'b0, 8'd6, 1'b0, 1'b0);
        #3;
        rst_n = 0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_array_en", 32'(array_en), 32'd0);
        chk("arst_rd_en", 32'(rd_en), 32'd0);
        chk("arst_row_vld", 32'(row_vld), 32'd0);
        chk("arst_col_vld", 32'(col_vld), 32'd0);
        m_act = 0; m_clr = 0; m_adv = 0;
        repeat (2) @(negedge clock);
        rst_n = 1;
        begin_scn();
        idle_steps(5);
        chk("arst_no_done", 32'(done_cyc), 32'hffffffff);

        // random traffic
        for (int s = 0; s < 600; s++) begin
            logic st, h, ab;
            logic [KW-1:0] kl;
            st = ($urandom_range(0, 3) == 0);
            kl = KW'($urandom_range(0, 12));
            h  = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 39) == 0);
            step(st, kl, h, ab);
        end
        idle_steps(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sysarray_ctrl.md
Name: sysarray_ctrl

Overview:
- Sequencer for the NxN output-stationary systolic array of multiply-accumulate PEs (each PE registers a/b pass-through and c+a*b every clock).
- On start, it pulses an accumulator clear, streams K operand-buffer addresses and keeps the array advancing until the last product settles in PE(N-1,N-1). It then pulses done/capture.
- Also produces per-row/per-column valid masks so the skew feeder injects zeros outside the valid window.

Parameters:
- N, 4, array dimension (rows = cols = N); 2N <= 2^KW
- KW, 8, width of k_len and rd_addr; max inner dimension 2^KW-1

Ports:
- clock  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin operation; sampled only in IDLE
- k_len  in  KW  inner dimension K; sampled with accepted start
- hold  in  1  freeze sequencing (upstream buffer not ready)
- abort  in  1  cancel current operation
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- acc_clr  out  1  one-cycle clear of all PE accumulators
- array_en  out  1  clock-enable for array registers and skew delay lines
- rd_en  out  1  operand buffer read strobe (A and B share the index)
- rd_addr  out  KW  operand index k
- row_vld  out  N  row i skewed input carries valid data
- col_vld  out  N  column j skewed input carries valid data

Behaviour:
- Reset: rst_n low forces state IDLE, cnt=0, k_reg=0 and all outputs 0 immediately, independent of clock. This applies mid-operation; no done is issued.
- States: IDLE, CLEAR, RUN, DONE. Counter cnt is KW+1 bits wide.
- IDLE: when start=1, latch k_reg=k_len and go to CLEAR.
- CLEAR (1 cycle): acc_clr=1, busy=1, cnt<=0. If k_reg==0, go directly to DONE (result is all zeros, no reads). Otherwise go to RUN.
- RUN: busy=1.
  - When hold=0: array_en=1 and cnt increments.
  - rd_en = (cnt < k_reg) && !hold; rd_addr = cnt[KW-1:0] when rd_en=1, else 0.
  - Read latency is 1 cycle.
  - row_vld[i] = !hold && (cnt >= i+1) && (cnt < i+1+k_reg); col_vld[j] uses the same formula with j.
  - Exit to DONE after the cycle in which cnt == k_reg+2N-1 with hold=0. Total advancing cycles L = k_reg+2N (1 read latency + 2(N-1) skew + 1 PE register).
- DONE (1 cycle): done=1, busy=1, array_en=0. Next state is IDLE.
- hold=1 in RUN: cnt frozen; array_en, rd_en, row_vld and col_vld all 0. hold is ignored in IDLE, CLEAR and DONE.
- abort=1 in CLEAR or RUN: go to IDLE next cycle with no done. Abort has priority over hold and over the RUN->DONE transition. Abort is ignored in IDLE and DONE.
- start while busy (CLEAR, RUN or DONE) is ignored, including the DONE cycle. Start is re-sampled in the first IDLE cycle.
- k_len changes after acceptance have no effect.
- Latency with no hold: start at cycle 0 -> acc_clr at cycle 1 -> RUN cycles 2..k+2N+1 -> done at cycle k+2N+2.
- All outputs are registered or decoded from registered state/cnt plus the hold input. There is no combinational path from start, k_len or abort to any output.

Decomposition:
- Package sysarray_pkg: state encoding (IDLE=2'd0, CLEAR=2'd1, RUN=2'd2, DONE=2'd3), default N, KW, and localparam DRAIN=2N.
- Sub-module sysarray_vld_mask: combinational generation of the row_vld/col_vld vectors from cnt, k_reg and hold, using a generate loop over N. It is shared by the row and column instances.

Test Plan:
- N=4, k_len=3, start at cycle 0, no hold:
  - acc_clr=1 at cycle 1.
  - rd_en=1 with rd_addr 0,1,2 at cycles 2-4.
  - row_vld[0] high at cycles 3-5 and row_vld[3] high at cycles 6-8.
  - array_en high at cycles 2-12.
  - done=1 at cycle 13; busy high at cycles 1-13.
- k_len=0, start at cycle 0 -> acc_clr at cycle 1, done at cycle 2, rd_en never asserted.
- k_len=3 with hold=1 during cycles 3-4:
  - rd_addr 1 is delayed to cycle 5.
  - All enables and masks are 0 at cycles 3-4.
  - done moves to cycle 15.
- abort=1 at cycle 6 of a k_len=5 run -> IDLE at cycle 7, busy=0, done never pulses. A new start at cycle 7 is accepted (acc_clr at cycle 8).
- start held high continuously with k_len=2 -> back-to-back operations: done at cycle 12, next acc_clr at cycle 14. The start pulse at cycle 12 (DONE state) is ignored.
- rst_n low asynchronously mid-RUN (between clock edges) -> all outputs 0 immediately. After release, stays in IDLE until start.
